// File: rtl/bldc_pkg.sv
// Shared types, commutation table and Hall decode for the BLDC commutator.
package bldc_pkg;

    typedef logic [2:0] sector_t;

    localparam sector_t SECTOR_NONE = 3'd7;

    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_B = 2'd1,
        PH_C = 2'd2
    } phase_t;

    // Forward-direction drive pair for one sector: hi is PWM'd, lo is held on.
    typedef struct packed {
        phase_t hi;
        phase_t lo;
    } comm_t;

    localparam comm_t COMM_TBL [6] = '{
        '{hi: PH_A, lo: PH_B},
        '{hi: PH_A, lo: PH_C},
        '{hi: PH_B, lo: PH_C},
        '{hi: PH_B, lo: PH_A},
        '{hi: PH_C, lo: PH_A},
        '{hi: PH_C, lo: PH_B}
    };

    // Hall code {H1,H2,H3} to sector; 000 and 111 are not legal Hall states.
    function automatic sector_t hall_decode(input logic [2:0] code);
        case (code)
            3'b100:  return 3'd0;
            3'b101:  return 3'd1;
            3'b001:  return 3'd2;
            3'b011:  return 3'd3;
            3'b010:  return 3'd4;
            3'b110:  return 3'd5;
            default: return SECTOR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bldc_deadtime.sv
// One phase leg: registers the high/low gate pair and keeps them apart by
// at least DEAD_CYCLES off-cycles whenever the leg changes side.
module bldc_deadtime #(
    parameter int DEAD_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_hi,
    input  logic i_req_lo,
    output logic o_gate_hi,
    output logic o_gate_lo
);

    localparam int            CW     = $clog2(DEAD_CYCLES + 1);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD_CYCLES);

    logic [CW-1:0] r_off_hi;
    logic [CW-1:0] r_off_lo;
    logic          r_gate_hi;
    logic          r_gate_lo;
    logic          w_hi_nxt;
    logic          w_lo_nxt;

    // A side may turn on only when the other side has been off long enough;
    // a simultaneous request of both sides turns neither on.
    assign w_hi_nxt = i_req_hi && !i_req_lo && (r_off_lo >= DEAD_C);
    assign w_lo_nxt = i_req_lo && !i_req_hi && (r_off_hi >= DEAD_C);

    // Gate registers plus saturating off-time counters; the counters follow the
    // next gate value so the off-cycle count includes the cycle being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gate_hi <= 1'b0;
            r_gate_lo <= 1'b0;
            r_off_hi  <= '0;
            r_off_lo  <= '0;
        end else begin
            r_gate_hi <= w_hi_nxt;
            r_gate_lo <= w_lo_nxt;
            r_off_hi  <= w_hi_nxt ? '0 : ((r_off_hi == DEAD_C) ? r_off_hi : r_off_hi + 1'b1);
            r_off_lo  <= w_lo_nxt ? '0 : ((r_off_lo == DEAD_C) ? r_off_lo : r_off_lo + 1'b1);
        end
    end

    assign o_gate_hi = r_gate_hi;
    assign o_gate_lo = r_gate_lo;

endmodule

// File: rtl/bldc_commutator_pwm.sv
// Hall-commutated BLDC gate controller: Hall sync/filter, sector decode,
// PWM on the high side, per-phase dead time, enable and sticky Hall fault.
module bldc_commutator_pwm
    import bldc_pkg::*;
#(
    parameter int DUTY_W      = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int HALL_FILT   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_dir,
    input  logic              i_h1,
    input  logic              i_h2,
    input  logic              i_h3,
    input  logic [DUTY_W-1:0] i_d,
    output logic              o_a,
    output logic              o_b,
    output logic              o_c,
    output logic              o_aa,
    output logic              o_bb,
    output logic              o_cc,
    output logic              o_fault,
    output logic [2:0]        o_sector
);

    localparam int            FW = $clog2(HALL_FILT + 1);
    localparam logic [FW-1:0] HF = FW'(HALL_FILT);

    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_cand;
    logic [FW-1:0]     r_fcnt;
    logic [FW-1:0]     w_fcnt_nxt;
    logic [2:0]        r_code;
    logic              r_code_vld;
    logic [DUTY_W-1:0] r_pcnt;
    logic [DUTY_W-1:0] r_duty;
    logic              w_pwm_on;
    sector_t           w_dec;
    logic              w_code_bad;
    logic              r_fault;
    sector_t           r_sector;
    logic              w_drive;
    phase_t            w_hi_ph;
    phase_t            w_lo_ph;
    logic [2:0]        w_req_hi;
    logic [2:0]        w_req_lo;
    logic [2:0]        w_gate_hi;
    logic [2:0]        w_gate_lo;

    // Two-flop synchroniser for the asynchronous Hall pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_h1, i_h2, i_h3};
            r_sync2 <= r_sync1;
        end
    end

    // Run length of the current synchronised sample, saturating at HALL_FILT.
    always_comb begin
        w_fcnt_nxt = r_fcnt;
        if (r_sync2 != r_cand)
            w_fcnt_nxt = FW'(1);
        else if (r_fcnt < HF)
            w_fcnt_nxt = r_fcnt + 1'b1;
    end

    // Glitch filter: accept a code once it has been seen HALL_FILT times in a
    // row. r_code_vld keeps the power-up 000 from reading as a Hall fault.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand     <= '0;
            r_fcnt     <= '0;
            r_code     <= '0;
            r_code_vld <= 1'b0;
        end else begin
            r_cand <= r_sync2;
            r_fcnt <= w_fcnt_nxt;
            if (w_fcnt_nxt == HF) begin
                r_code     <= r_sync2;
                r_code_vld <= 1'b1;
            end
        end
    end

    // PWM period counter; duty is reloaded on the last count of a period, and
    // continuously while disabled so a fresh enable starts at the commanded duty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
            r_duty <= '0;
        end else begin
            r_pcnt <= i_en ? r_pcnt + 1'b1 : '0;
            if (!i_en || (r_pcnt == '1))
                r_duty <= i_d;
        end
    end

    assign w_pwm_on   = (r_pcnt < r_duty);
    assign w_dec      = r_code_vld ? hall_decode(r_code) : SECTOR_NONE;
    assign w_code_bad = r_code_vld && (w_dec == SECTOR_NONE);
    assign w_drive    = i_en && !r_fault && !w_code_bad && (w_dec != SECTOR_NONE);

    // Sticky fault and registered sector; EN low clears the fault.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fault  <= 1'b0;
            r_sector <= SECTOR_NONE;
        end else begin
            r_fault  <= i_en && (r_fault || w_code_bad);
            r_sector <= (i_en && r_fault) ? SECTOR_NONE : w_dec;
        end
    end

    // Gate requests from the commutation table; reverse swaps the two sides.
    always_comb begin
        w_req_hi = '0;
        w_req_lo = '0;
        w_hi_ph  = PH_A;
        w_lo_ph  = PH_A;
        if (w_drive) begin
            w_hi_ph           = i_dir ? COMM_TBL[w_dec].lo : COMM_TBL[w_dec].hi;
            w_lo_ph           = i_dir ? COMM_TBL[w_dec].hi : COMM_TBL[w_dec].lo;
            w_req_hi[w_hi_ph] = w_pwm_on;
            w_req_lo[w_lo_ph] = 1'b1;
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_phase
        bldc_deadtime #(
            .DEAD_CYCLES(DEAD_CYCLES)
        ) u_dt (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_req_hi  (w_req_hi[p]),
            .i_req_lo  (w_req_lo[p]),
            .o_gate_hi (w_gate_hi[p]),
            .o_gate_lo (w_gate_lo[p])
        );
    end

    assign o_a      = w_gate_hi[0];
    assign o_b      = w_gate_hi[1];
    assign o_c      = w_gate_hi[2];
    assign o_aa     = w_gate_lo[0];
    assign o_bb     = w_gate_lo[1];
    assign o_cc     = w_gate_lo[2];
    assign o_fault  = r_fault;
    assign o_sector = r_sector;

endmodule

// File: tb/tb_bldc_commutator_pwm.sv
// Bench for bldc_commutator_pwm (DUTY_W=8, DEAD_CYCLES=4, HALL_FILT=3).
module tb_bldc_commutator_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       h1, h2, h3;
    logic [7:0] d;
    logic       a, b, c, aa, bb, cc, fault;
    logic [2:0] sector;

    always #5 clk = ~clk;

    bldc_commutator_pwm #(
        .DUTY_W(8), .DEAD_CYCLES(4), .HALL_FILT(3)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir),
        .i_h1(h1), .i_h2(h2), .i_h3(h3), .i_d(d),
        .o_a(a), .o_b(b), .o_c(c), .o_aa(aa), .o_bb(bb), .o_cc(cc),
        .o_fault(fault), .o_sector(sector)
    );

    wire [2:0] hi = {c, b, a};
    wire [2:0] lo = {cc, bb, aa};

    int n_vec   = 0;
    int n_bad   = 0;
    int n_shoot = 0;

    typedef struct {
        logic [2:0] hall;
        logic       dir;
        logic [2:0] sec;
        logic [2:0] hi;   // one-hot {C,B,A} PWM'd high side
        logic [2:0] lo;   // one-hot {C,B,A} low side held on
    } vec_t;

    vec_t vt [12];
    vec_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [26:0] exp_hi(input logic [2:0] m, input int duty);
        return {m[2] ? 9'(duty) : 9'd0, m[1] ? 9'(duty) : 9'd0, m[0] ? 9'(duty) : 9'd0};
    endfunction

    // Over one full PWM period: on-count of each high gate and AND/OR of low gates.
    task automatic measure(output logic [26:0] hcnt, output logic [5:0] lacc);
        logic [8:0] ca, cbn, ccn;
        logic [2:0] land, lor;
        ca = '0; cbn = '0; ccn = '0; land = 3'b111; lor = 3'b000;
        for (int k = 0; k < 256; k++) begin
            tick();
            ca   += 9'(a);
            cbn  += 9'(b);
            ccn  += 9'(c);
            land &= lo;
            lor  |= lo;
        end
        hcnt = {ccn, cbn, ca};
        lacc = {land, lor};
    endtask

    // Same-phase high and low must never be on together.
    always @(negedge clk)
        if (rst_n === 1'b1 && ((a & aa) | (b & bb) | (c & cc)))
            n_shoot++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin
        logic [26:0] hc;
        logic [5:0]  la;
        vec_t        e;
        logic        found, held, prev;
        int          cnt;

        vt[0]  = '{3'b100, 1'b0, 3'd0, 3'b001, 3'b010};
        vt[1]  = '{3'b101, 1'b0, 3'd1, 3'b001, 3'b100};
        vt[2]  = '{3'b001, 1'b0, 3'd2, 3'b010, 3'b100};
        vt[3]  = '{3'b011, 1'b0, 3'd3, 3'b010, 3'b001};
        vt[4]  = '{3'b010, 1'b0, 3'd4, 3'b100, 3'b001};
        vt[5]  = '{3'b110, 1'b0, 3'd5, 3'b100, 3'b010};
        vt[6]  = '{3'b100, 1'b1, 3'd0, 3'b010, 3'b001};
        vt[7]  = '{3'b101, 1'b1, 3'd1, 3'b100, 3'b001};
        vt[8]  = '{3'b001, 1'b1, 3'd2, 3'b100, 3'b010};
        vt[9]  = '{3'b011, 1'b1, 3'd3, 3'b001, 3'b010};
        vt[10] = '{3'b010, 1'b1, 3'd4, 3'b001, 3'b100};
        vt[11] = '{3'b110, 1'b1, 3'd5, 3'b010, 3'b100};

        {h1, h2, h3} = 3'b100; d = 8'd128; en = 1'b0; dir = 1'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        chk("reset_gates", {hi, lo}, 6'b0);
        chk("reset_sector", sector, 3'd7);
        chk("reset_fault", fault, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        tick(10);
        en = 1'b1;

        // Every sector in both directions at 50% duty.
        for (int i = 0; i < 12; i++) begin
            {h1, h2, h3} = vt[i].hall;
            dir = vt[i].dir;
            sb.push_back(vt[i]);
            tick(20);
            measure(hc, la);
            e = sb.pop_front();
            chk($sformatf("v%0d_sector", i), sector, e.sec);
            chk($sformatf("v%0d_lo", i), la, {e.lo, e.lo});
            chk($sformatf("v%0d_hi_cnt", i), hc, exp_hi(e.hi, 128));
        end

        // Two-sample Hall glitch is rejected.
        {h1, h2, h3} = 3'b100; dir = 1'b0; tick(30);
        held = 1'b1;
        {h1, h2, h3} = 3'b101; tick(2); {h1, h2, h3} = 3'b100;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sector !== 3'd0 || bb !== 1'b1) held = 1'b0;
        end
        chk("glitch_no_change", held, 1'b1);

        // Sustained change lands exactly six cycles after the first sampling edge.
        {h1, h2, h3} = 3'b101;
        tick(5);
        chk("lat5_sector", sector, 3'd0);
        chk("lat5_bbcc", {bb, cc}, 2'b10);
        tick();
        chk("lat6_sector", sector, 3'd1);
        chk("lat6_bbcc", {bb, cc}, 2'b01);

        // Direction reversal in sector 0 while A is on.
        {h1, h2, h3} = 3'b100; tick(30);
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            tick();
            if (a) found = 1'b1;
        end
        chk("dir_a_high_seen", found, 1'b1);
        dir = 1'b1;
        tick();
        chk("dir_a_off", a, 1'b0);
        chk("dir_bb_off", bb, 1'b0);
        tick(3);
        chk("dir_aa_dead", aa, 1'b0);
        tick();
        chk("dir_aa_on", aa, 1'b1);
        tick(20);
        measure(hc, la);
        chk("dir_b_pwm", hc, exp_hi(3'b010, 128));
        chk("dir_lo", la, {3'b001, 3'b001});

        // Invalid Hall code: sticky fault, cleared by an EN pulse.
        dir = 1'b0; tick(30);
        {h1, h2, h3} = 3'b111;
        tick(5);
        chk("flt_lat5", fault, 1'b0);
        tick();
        chk("flt_set", fault, 1'b1);
        chk("flt_gates", {hi, lo}, 6'b0);
        chk("flt_sector", sector, 3'd7);
        {h1, h2, h3} = 3'b100; tick(30);
        chk("flt_sticky", fault, 1'b1);
        chk("flt_sticky_gates", {hi, lo}, 6'b0);
        chk("flt_sticky_sector", sector, 3'd7);
        en = 1'b0;
        tick();
        chk("flt_clear", fault, 1'b0);
        chk("en_off_gates", {hi, lo}, 6'b0);
        en = 1'b1;
        tick(20);
        measure(hc, la);
        chk("resume_hi_cnt", hc, exp_hi(3'b001, 128));
        chk("resume_lo", la, {3'b010, 3'b010});
        chk("resume_sector", sector, 3'd0);

        // Duty change mid-period takes effect from the next period.
        d = 8'd64; tick(300);
        prev = a; found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            tick();
            if (a && !prev) found = 1'b1;
            prev = a;
        end
        chk("duty_rise_seen", found, 1'b1);
        cnt = int'(a);
        for (int j = 1; j < 256; j++) begin
            tick();
            cnt += int'(a);
            if (j == 9) d = 8'd200;
        end
        chk("duty_cur_period", cnt, 64);
        cnt = 0;
        for (int j = 0; j < 256; j++) begin
            tick();
            cnt += int'(a);
        end
        chk("duty_next_period", cnt, 200);

        // Asynchronous reset while driving.
        chk("pre_reset_bb", bb, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_gates", {hi, lo}, 6'b0);
        chk("areset_sector", sector, 3'd7);
        chk("areset_fault", fault, 1'b0);
        tick(3); rst_n = 1'b1;
        tick(20);
        chk("post_reset_sector", sector, 3'd0);

        // Asynchronous reset clears a set fault.
        {h1, h2, h3} = 3'b111; tick(10);
        chk("pre_reset_fault", fault, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_fault_clr", fault, 1'b0);
        chk("areset_fault_sector", sector, 3'd7);
        tick(); rst_n = 1'b1;

        chk("no_shoot_through", n_shoot, 0);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bldc_commutator_pwm.md
Name: bldc_commutator_pwm

Overview:
Parametrised successor to the fixed-width Hall-commutated BLDC controller. It converts three Hall inputs and a duty word into six gate drives: A/AA, B/BB and C/CC, high and low side per phase. New capabilities: parametrised PWM resolution, Hall synchronisation and glitch filtering, direction control, per-phase dead-time insertion, enable, and a sticky Hall-fault flag. It sits between the Hall sensor pins and the gate-driver IC.

Parameters:
- DUTY_W, 8: width of duty input and PWM counter; PWM period is 2^DUTY_W cycles.
- DEAD_CYCLES, 4: minimum cycles a gate must be off before its same-phase complement may turn on (≥1).
- HALL_FILT, 3: consecutive identical synchronised Hall samples required to accept a new code (≥1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  drive enable; 0 forces all gates off and clears FAULT.
- DIR  in  1  0 = forward, 1 = reverse.
- H1, H2, H3  in  1 each  raw asynchronous Hall inputs.
- D  in  DUTY_W  duty command.
- A, B, C  out  1 each  high-side gates.
- AA, BB, CC  out  1 each  low-side gates.
- FAULT  out  1  sticky invalid-Hall flag.
- SECTOR  out  3  current decoded sector 0..5; 7 means none or invalid.

Behaviour:
- Reset (async, RST_N=0): all six gates 0, FAULT=0, SECTOR=7, PWM counter 0, filters cleared, dead-time counters 0.
- Hall path:
  - 2-FF synchroniser on each of H1..H3.
  - The filtered code {H1,H2,H3} updates only after HALL_FILT consecutive identical synchronised samples.
- Decode, code → sector: 100→0, 101→1, 001→2, 011→3, 010→4, 110→5; 000 and 111 are invalid. SECTOR is registered.
- Commutation, forward (high+, low−): s0 A+B−, s1 A+C−, s2 B+C−, s3 B+A−, s4 C+A−, s5 C+B−.
- Commutation, reverse: same table with high and low swapped (s0 B+A−, etc.).
- PWM counter:
  - Free-running 0..2^DUTY_W−1 with wrap; runs only while EN=1, held at 0 otherwise.
  - D is latched into the duty register when the counter reaches its maximum (the last cycle of a period), so a new value takes effect from the next period.
  - pwm_on = counter < latched duty. D=0 gives always off; D=max gives on for 2^DUTY_W−1 of 2^DUTY_W cycles.
- Gate request:
  - The active high-side gate is requested as pwm_on.
  - The active low-side gate is requested continuously at 1.
  - All other gates are requested 0.
- Dead time, per phase (sub-module):
  - Each gate has a saturating off-counter that counts cycles the gate output has been 0 and resets to 0 while it is 1.
  - A gate output turns on only if requested AND its complement's off-counter ≥ DEAD_CYCLES.
  - Turn-off is immediate, in the next registered cycle.
  - High and low of the same phase are never 1 simultaneously, including on DIR change, reset release or EN toggling.
- Latency: a Hall input change reaches the gate outputs 2 + HALL_FILT + 1 cycles after the first sampling edge, plus dead time if the same phase swaps side.
- Fault:
  - An invalid filtered code while EN=1 sets FAULT=1 and forces all gates 0 and SECTOR=7.
  - FAULT is sticky even if valid codes return; it is cleared only by EN=0 or reset.
- EN=0: gates 0 on the next clock and FAULT cleared. After EN rises, dead-time rules apply normally.
- DIR change mid-sector takes effect on the next cycle; shoot-through is prevented only by the dead-time logic.
- Simultaneous Hall change and PWM wrap are independent; both are applied in the same cycle.

Decomposition:
- Shared package bldc_pkg holds:
  - the sector index type;
  - SECTOR_NONE = 3'd7;
  - the Hall-code to sector decode function;
  - the commutation table constant, as a 6-entry array of {hi_phase, lo_phase}.
- One sub-module, bldc_deadtime, instantiated three times with params DEAD_CYCLES. Inputs: req_hi and req_lo. Outputs: registered gate_hi and gate_lo.

Test Plan (DUTY_W=8, DEAD_CYCLES=4, HALL_FILT=3):
1. Reset: RST_N=0 mid-run → all gates 0, SECTOR=7, FAULT=0 immediately and asynchronously.
2. EN=1, DIR=0, D=128, Hall 100:
   - SECTOR=0.
   - A high for 128 of every 256 cycles.
   - BB=1 constant.
   - B, C, AA, CC = 0.
3. Glitch and commutation, from test 2:
   - A 2-cycle pulse 100→101→100 → no change.
   - A sustained change to 101 → SECTOR=1 and BB↓ / CC↑ exactly 6 cycles after first sampling.
4. DIR 0→1 in sector 0 → A↓ next cycle; AA↑ 4 cycles after A went low; B PWMs.
5. Fault:
   - Hall 111 → FAULT=1 and all gates 0 after 6 cycles.
   - Returning to 100 keeps FAULT=1.
   - Pulsing EN=0 clears FAULT, and the gates resume.
6. Duty update: D changed from 64 to 200 at counter=10 → current period still 64 on-cycles; next period 200.
